out_alu_control_unit: RTL

//  Downstream stage of the ALU. Collects adder and multiplier results, each tagged with its

---
 rtl/out_alu_control_unit_if.sv | 35 +++
 rtl/out_alu_control_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/out_alu_control_unit_if.sv
// Bundle between the ALU result side, the output controller and FIFO_OUT.
// Result handshake: a source presents *_valid_res with result/id; the word is
// taken on a rising edge where *_valid_res & *_res_ready are both high, and the
// source must hold it stable until then. w_en_out is a one-cycle write strobe.
interface out_alu_control_unit_if #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int CNT_SIZE       = 16
);
  localparam int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE;

  logic                      a_valid_res;
  logic [DATA_SIZE-1:0]      a_result;
  logic [ID_SIZE-1:0]        a_id;
  logic                      a_res_ready;
  logic                      m_valid_res;
  logic [DATA_SIZE-1:0]      m_result;
  logic [ID_SIZE-1:0]        m_id;
  logic                      m_res_ready;
  logic                      full_out;
  logic                      w_en_out;
  logic [FIFO_OUT_WIDTH-1:0] fifo_out_data;
  logic [CNT_SIZE-1:0]       wr_count;

  modport master (
    output a_valid_res, a_result, a_id, m_valid_res, m_result, m_id, full_out,
    input  a_res_ready, m_res_ready, w_en_out, fifo_out_data, wr_count
  );

  modport slave (
    input  a_valid_res, a_result, a_id, m_valid_res, m_result, m_id, full_out,
    output a_res_ready, m_res_ready, w_en_out, fifo_out_data, wr_count
  );
endinterface

// File: rtl/out_alu_control_unit.sv
// Output stage of the ALU: one holding register per result source, a
// round-robin arbiter, and single-cycle writes of {result, id, op} to FIFO_OUT.
module out_alu_control_unit #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int CNT_SIZE       = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  out_alu_control_unit_if.slave bus
);
  localparam int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE;
  localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(2);

  typedef enum logic {SRC_ADD = 1'b0, SRC_MUL = 1'b1} src_e;

  logic [DATA_SIZE-1:0]      a_res_q, a_res_d, m_res_q, m_res_d;
  logic [ID_SIZE-1:0]        a_id_q, a_id_d, m_id_q, m_id_d;
  logic                      a_vld_q, a_vld_d, m_vld_q, m_vld_d;
  src_e                      last_grant_q, last_grant_d;
  logic                      w_en_q, w_en_d;
  logic [FIFO_OUT_WIDTH-1:0] data_q, data_d;
  logic [CNT_SIZE-1:0]       wr_count_d, wr_count_q;
  logic                      grant;
  logic                      pick_m;

  always_comb begin
    a_res_d      = a_res_q;
    a_id_d       = a_id_q;
    a_vld_d      = a_vld_q;
    m_res_d      = m_res_q;
    m_id_d       = m_id_q;
    m_vld_d      = m_vld_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    wr_count_d   = wr_count_q;
    w_en_d       = 1'b0;

    // Blocking on w_en_q spaces writes so full_out has caught up before the next grant.
    grant  = !bus.full_out && !w_en_q && (a_vld_q || m_vld_q);
    pick_m = m_vld_q && (!a_vld_q || last_grant_q == SRC_ADD);

    // Capture only into an empty register, so capture and grant never collide.
    if (bus.a_valid_res && !a_vld_q) begin
      a_res_d = bus.a_result;
      a_id_d  = bus.a_id;
      a_vld_d = 1'b1;
    end
    if (bus.m_valid_res && !m_vld_q) begin
      m_res_d = bus.m_result;
      m_id_d  = bus.m_id;
      m_vld_d = 1'b1;
    end

    if (grant) begin
      w_en_d     = 1'b1;
      wr_count_d = wr_count_q + CNT_SIZE'(1);
      if (pick_m) begin
        data_d       = {m_res_q, m_id_q, OP_MUL};
        m_vld_d      = 1'b0;
        last_grant_d = SRC_MUL;
      end else begin
        data_d       = {a_res_q, a_id_q, OP_ADD};
        a_vld_d      = 1'b0;
        last_grant_d = SRC_ADD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_res_q      <= '0;
      a_id_q       <= '0;
      a_vld_q      <= 1'b0;
      m_res_q      <= '0;
      m_id_q       <= '0;
      m_vld_q      <= 1'b0;
      last_grant_q <= SRC_MUL;
      w_en_q       <= 1'b0;
      data_q       <= '0;
      wr_count_q   <= '0;
    end else begin
      a_res_q      <= a_res_d;
      a_id_q       <= a_id_d;
      a_vld_q      <= a_vld_d;
      m_res_q      <= m_res_d;
      m_id_q       <= m_id_d;
      m_vld_q      <= m_vld_d;
      last_grant_q <= last_grant_d;
      w_en_q       <= w_en_d;
      data_q       <= data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign bus.a_res_ready   = !a_vld_q;
  assign bus.m_res_ready   = !m_vld_q;
  assign bus.w_en_out      = w_en_q;
  assign bus.fifo_out_data = data_q;
  assign bus.wr_count      = wr_count_q;
endmodule
